alu_uart_ctrl: RTL
==================

ALU_UART_CTRL -- requirements
Module: alu_uart_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of UART bytes and ALU operands.
REQ-002 SHALL have parameter OP_WIDTH, default 6, width of ALU opcode (low bits of the opcode byte).
REQ-003 SHALL have parameter TIMEOUT, default 5_000_000, clk cycles allowed between bytes of one frame (50 ms at 100 MHz).
REQ-004 SHALL have ports: clk  in  1  system clock, one clock domain; all logic on rising edge.
REQ-005 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports: i_rx_done  in  1  one-cycle pulse from uart_rx; byte valid on i_rx_data that cycle.
REQ-007 SHALL have ports: i_rx_data  in  DATA_WIDTH  received byte.
REQ-008 SHALL have ports: i_alu_result  in  DATA_WIDTH  combinational ALU result for o_a/o_b/o_op.
REQ-009 SHALL have ports: i_tx_done  in  1  one-cycle pulse from uart_tx at end of stop bit.
REQ-010 SHALL have ports: o_a, o_b  out  DATA_WIDTH  registered operands to ALU.
REQ-011 SHALL have ports: o_op  out  OP_WIDTH  registered opcode to ALU.
REQ-012 SHALL have ports: o_tx_start  out  1  one-cycle start pulse to uart_tx.
REQ-013 SHALL have ports: o_tx_data  out  DATA_WIDTH  byte to transmit, stable from o_tx_start until i_tx_done.
REQ-014 SHALL have ports: o_busy  out  1  high in EXEC, SEND, WAIT_TX.
REQ-015 SHALL have ports: o_err  out  1  sticky; set on timeout or dropped byte, cleared only by reset.

Function
REQ-016 SHALL implement FSM states WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX; encoding binary.
REQ-017 WAIT_A: on i_rx_done, o_a <= i_rx_data, go WAIT_B; no timeout in WAIT_A.
REQ-018 WAIT_B: on i_rx_done, o_b <= i_rx_data, go WAIT_OP.
REQ-019 WAIT_OP: on i_rx_done, o_op <= i_rx_data[OP_WIDTH-1:0], go EXEC; upper byte bits discarded.
REQ-020 EXEC: one cycle for ALU settle; o_tx_data <= i_alu_result; go SEND.
REQ-021 SEND: o_tx_start = 1 for exactly this one cycle; go WAIT_TX.
REQ-022 WAIT_TX: on i_tx_done go WAIT_A; o_tx_data held unchanged.
REQ-023 Latency: o_tx_start asserts exactly 2 clk after the cycle i_rx_done delivers the opcode byte.
REQ-024 Timeout counter SHALL clear on every accepted byte and count each cycle in WAIT_B/WAIT_OP; reaching TIMEOUT-1 -> go WAIT_A, set o_err, o_a/o_b/o_op retain values.
REQ-025 i_rx_done in EXEC/SEND/WAIT_TX SHALL be dropped (no register change) and set o_err.
REQ-026 i_rx_done coincident with timeout expiry SHALL accept the byte (byte wins, counter clears, no o_err).
REQ-027 i_tx_done outside WAIT_TX SHALL be ignored.
REQ-028 Counter width SHALL be $clog2(TIMEOUT); no wrap beyond TIMEOUT-1.

Reset
REQ-029 reset SHALL force state WAIT_A, counter 0, o_a/o_b/o_tx_data = 0, o_op = 0, o_tx_start = 0, o_busy = 0, o_err = 0 on the next clk edge.
REQ-030 reset mid-frame or mid-transmit SHALL abandon the frame; no o_tx_start after reset deasserts until a full new frame.

Structure
REQ-031 State encodings and default DATA_WIDTH/OP_WIDTH SHALL live in shared package uart_pkg, used by uart_rx/uart_tx benches too.
REQ-032 Timeout counter SHALL be a sub-module frame_timer (inputs clear, enable; output expired).
REQ-033 SHALL be single-clock, no latches, all outputs registered except o_busy (decoded from state register).

Verification
REQ-034 Bytes 0x05, 0x03, op 0x20, result 0x08 -> o_a=0x05, o_b=0x03, o_op=0x20, o_tx_start 2 cycles after op pulse, o_tx_data=0x08.
REQ-035 Op byte 0xE2 -> o_op=0x22 (upper bits dropped).
REQ-036 Byte 0x11 then no byte for TIMEOUT cycles (TIMEOUT=100 in bench) -> state WAIT_A, o_err=1, no o_tx_start.
REQ-037 Extra i_rx_done during WAIT_TX with data 0xAA -> o_tx_data unchanged, o_err=1, next frame still processed.
REQ-038 reset asserted in WAIT_OP for 1 cycle -> all outputs 0, following bytes 0x01,0x02,0x20 -> single o_tx_start.
REQ-039 Full loop with br_generator(100 MHz, 19200), uart_rx, ALU, uart_tx: send 0x0A,0x14,0x20 serially -> serial output 0x1E.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART byte-level blocks (uart_rx, uart_tx and the
// ALU command controller) and their benches.
//   - DATA_WIDTH_DEF / OP_WIDTH_DEF : default byte and opcode widths
//   - ctrl_state_t                  : controller FSM states, binary encoded
//   - is_busy_state()               : states in which the controller is busy
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int OP_WIDTH_DEF   = 6;

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } ctrl_state_t;

  // The controller is busy from the moment the opcode is in until the
  // transmitter reports the result byte has left.
  function automatic logic is_busy_state(input ctrl_state_t s);
    return (s == ST_EXEC) || (s == ST_SEND) || (s == ST_WAIT_TX);
  endfunction

endpackage

// File: rtl/frame_timer.sv
// -----------------------------------------------------------------------------
// frame_timer
// Inter-byte watchdog. Counts enabled cycles since the last clear and flags
// expiry once TIMEOUT-1 is reached; the count saturates there.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clear      : restart the count from zero (takes priority over enable)
//   enable     : count this cycle
//   expired    : count has reached TIMEOUT-1 while enabled
// -----------------------------------------------------------------------------
module frame_timer #(
  parameter int TIMEOUT = 5_000_000,
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != LAST)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // Gated by enable so a stale saturated count outside the byte-wait
  // states can never be mistaken for a live timeout.
  assign expired = enable && (count_reg == LAST);

endmodule

// File: rtl/alu_uart_ctrl.sv
// -----------------------------------------------------------------------------
// alu_uart_ctrl
// Collects a three-byte frame (operand A, operand B, opcode) from a UART
// receiver, presents it to an external combinational ALU, then hands the
// result byte to a UART transmitter and waits for it to finish.
// Ports:
//   clk, reset    : clock and synchronous active-high reset
//   i_rx_done     : one-cycle pulse, i_rx_data valid
//   i_rx_data     : received byte
//   i_alu_result  : ALU result for o_a/o_b/o_op
//   i_tx_done     : one-cycle pulse at end of transmitted stop bit
//   o_a, o_b      : registered ALU operands
//   o_op          : registered ALU opcode (low OP_WIDTH bits of opcode byte)
//   o_tx_start    : one-cycle transmit start pulse
//   o_tx_data     : byte to transmit, held until i_tx_done
//   o_busy        : high in EXEC, SEND, WAIT_TX
//   o_err         : sticky error (inter-byte timeout or dropped byte)
// -----------------------------------------------------------------------------
module alu_uart_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int OP_WIDTH   = OP_WIDTH_DEF,
  parameter int TIMEOUT    = 5_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_rx_done,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  input  logic                  i_tx_done,
  output logic [DATA_WIDTH-1:0] o_a,
  output logic [DATA_WIDTH-1:0] o_b,
  output logic [OP_WIDTH-1:0]   o_op,
  output logic                  o_tx_start,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_busy,
  output logic                  o_err
);

  ctrl_state_t state_reg, state_next;

  logic [DATA_WIDTH-1:0] a_reg, b_reg, tx_data_reg;
  logic [OP_WIDTH-1:0]   op_reg;
  logic                  tx_start_reg, err_reg;

  logic load_a, load_b, load_op, load_tx, set_err;
  logic timer_enable, timer_expired;

  frame_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_frame_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (load_a | load_b | load_op),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  always_comb begin
    state_next   = state_reg;
    load_a       = 1'b0;
    load_b       = 1'b0;
    load_op      = 1'b0;
    load_tx      = 1'b0;
    set_err      = 1'b0;
    timer_enable = 1'b0;

    case (state_reg)
      ST_WAIT_A: begin
        if (i_rx_done) begin
          load_a     = 1'b1;
          state_next = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        timer_enable = 1'b1;
        // A byte arriving on the expiry cycle still counts.
        if (i_rx_done) begin
          load_b     = 1'b1;
          state_next = ST_WAIT_OP;
        end else if (timer_expired) begin
          set_err    = 1'b1;
          state_next = ST_WAIT_A;
        end
      end
      ST_WAIT_OP: begin
        timer_enable = 1'b1;
        if (i_rx_done) begin
          load_op    = 1'b1;
          state_next = ST_EXEC;
        end else if (timer_expired) begin
          set_err    = 1'b1;
          state_next = ST_WAIT_A;
        end
      end
      ST_EXEC: begin
        load_tx    = 1'b1;
        set_err    = i_rx_done;
        state_next = ST_SEND;
      end
      ST_SEND: begin
        set_err    = i_rx_done;
        state_next = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        set_err = i_rx_done;
        if (i_tx_done) begin
          state_next = ST_WAIT_A;
        end
      end
      default: begin
        state_next = ST_WAIT_A;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_WAIT_A;
      a_reg        <= '0;
      b_reg        <= '0;
      op_reg       <= '0;
      tx_data_reg  <= '0;
      tx_start_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (load_a)  a_reg       <= i_rx_data;
      if (load_b)  b_reg       <= i_rx_data;
      if (load_op) op_reg      <= i_rx_data[OP_WIDTH-1:0];
      if (load_tx) tx_data_reg <= i_alu_result;
      // Registered so the pulse lines up exactly with the SEND cycle.
      tx_start_reg <= (state_reg == ST_EXEC);
      if (set_err) err_reg <= 1'b1;
    end
  end

  assign o_a        = a_reg;
  assign o_b        = b_reg;
  assign o_op       = op_reg;
  assign o_tx_data  = tx_data_reg;
  assign o_tx_start = tx_start_reg;
  assign o_err      = err_reg;
  assign o_busy     = is_busy_state(state_reg);

endmodule
